// File: rtl/scoreboard_slot_ctrl.sv
// scoreboard_slot_ctrl: per-slot K/G/P status codes feeding the 16-slot prefix network.
module scoreboard_slot_ctrl #(
    parameter int NSLOT = 16,
    parameter int ID_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    output logic [ID_W-1:0]      alloc_id,
    input  logic                 cmpl_valid,
    input  logic [ID_W-1:0]      cmpl_id,
    input  logic                 ret_valid,
    input  logic [ID_W-1:0]      ret_id,
    input  logic                 flush,
    output logic [2*NSLOT-1:0]   r_bus,
    output logic [ID_W:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 err
);
    localparam logic [1:0] K = 2'b00;
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] G = 2'b10;

    logic [NSLOT-1:0][1:0] slot_q, slot_d;
    logic [ID_W:0]         count_q, count_d;
    logic                  err_q, err_d;
    logic                  any_free, grant, cmpl_ok, ret_ok;

    always_comb begin
        alloc_id = '0;
        any_free = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (slot_q[i] == K) begin
                alloc_id = ID_W'(i);
                any_free = 1'b1;
            end
        end
    end

    assign alloc_ready = any_free & ~flush;
    assign grant       = alloc_valid & alloc_ready;
    assign cmpl_ok     = cmpl_valid & (slot_q[cmpl_id] == P);
    assign ret_ok      = ret_valid & (slot_q[ret_id] == G);

    // A legal alloc targets a K slot, so it never collides with a legal cmpl or ret.
    always_comb begin
        slot_d  = slot_q;
        count_d = flush ? '0 : count_q + (ID_W+1)'(grant) - (ID_W+1)'(ret_ok);
        err_d   = err_q | (~flush & ((cmpl_valid & ~cmpl_ok) | (ret_valid & ~ret_ok)));
        if (flush) begin
            slot_d = '0;
        end else begin
            if (grant)   slot_d[alloc_id] = P;
            if (cmpl_ok) slot_d[cmpl_id]  = G;
            if (ret_ok)  slot_d[ret_id]   = K;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign r_bus = slot_q;
    assign count = count_q;
    assign full  = count_q == (ID_W+1)'(NSLOT);
    assign empty = count_q == '0;
    assign err   = err_q;
endmodule
